// File: rtl/csr_register_file_pkg.sv
// Shared CSR address map, write-op encodings, mstatus layout and decode helpers.
package csr_register_file_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CsrMstatus   = 12'h300;
    localparam logic [11:0] CsrMisa      = 12'h301;
    localparam logic [11:0] CsrMie       = 12'h304;
    localparam logic [11:0] CsrMtvec     = 12'h305;
    localparam logic [11:0] CsrMscratch  = 12'h340;
    localparam logic [11:0] CsrMepc      = 12'h341;
    localparam logic [11:0] CsrMcause    = 12'h342;
    localparam logic [11:0] CsrMtval     = 12'h343;
    localparam logic [11:0] CsrMip       = 12'h344;
    localparam logic [11:0] CsrMcycle    = 12'hB00;
    localparam logic [11:0] CsrMcycleh   = 12'hB80;
    localparam logic [11:0] CsrMinstret  = 12'hB02;
    localparam logic [11:0] CsrMinstreth = 12'hB82;
    // Read-only user-level aliases of the counters
    localparam logic [11:0] CsrCycle     = 12'hC00;
    localparam logic [11:0] CsrCycleh    = 12'hC80;
    localparam logic [11:0] CsrInstret   = 12'hC02;
    localparam logic [11:0] CsrInstreth  = 12'hC82;

    // mstatus field positions; MPP is hardwired to machine mode
    localparam int unsigned MstatusMieBit  = 3;
    localparam int unsigned MstatusMpieBit = 7;
    localparam logic [31:0] MstatusMppM    = 32'h0000_1800;

    typedef enum logic [1:0] {
        WdWrite    = 2'b00,
        WdSet      = 2'b01,
        WdClear    = 2'b10,
        WdReserved = 2'b11
    } csr_wd_sel_e;

    // Decoded storage target; aliases share the target of their machine counterpart
    typedef enum logic [3:0] {
        SelNone,
        SelMstatus,
        SelMisa,
        SelMie,
        SelMtvec,
        SelMscratch,
        SelMepc,
        SelMcause,
        SelMtval,
        SelMip,
        SelMcycle,
        SelMcycleh,
        SelMinstret,
        SelMinstreth
    } csr_sel_e;

    function automatic csr_sel_e csr_decode(input logic [11:0] addr);
        csr_sel_e sel;
        case (addr)
            CsrMstatus:               sel = SelMstatus;
            CsrMisa:                  sel = SelMisa;
            CsrMie:                   sel = SelMie;
            CsrMtvec:                 sel = SelMtvec;
            CsrMscratch:              sel = SelMscratch;
            CsrMepc:                  sel = SelMepc;
            CsrMcause:                sel = SelMcause;
            CsrMtval:                 sel = SelMtval;
            CsrMip:                   sel = SelMip;
            CsrMcycle,   CsrCycle:    sel = SelMcycle;
            CsrMcycleh,  CsrCycleh:   sel = SelMcycleh;
            CsrMinstret, CsrInstret:  sel = SelMinstret;
            CsrMinstreth, CsrInstreth: sel = SelMinstreth;
            default:                  sel = SelNone;
        endcase
        return sel;
    endfunction

    // addr[11:10]==11 is the read-only CSR space; misa is read-only here as well
    function automatic logic csr_is_read_only(input logic [11:0] addr);
        return (addr[11:10] == 2'b11) || (addr == CsrMisa);
    endfunction

    function automatic logic [31:0] csr_apply_op(input csr_wd_sel_e op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] src);
        logic [31:0] res;
        case (op)
            WdSet:   res = old_val | src;
            WdClear: res = old_val & ~src;
            default: res = src;  // write, and the reserved encoding
        endcase
        return res;
    endfunction

    function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
        logic [31:0] val;
        val = MstatusMppM;
        val[MstatusMieBit]  = mie;
        val[MstatusMpieBit] = mpie;
        return val;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and independent 32-bit half writes.
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        lo_we_i,
    input  logic        hi_we_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic        lo_carry;

    // Written half takes wdata; a lo write suppresses both its increment and the carry
    always_comb begin
        lo_d     = lo_q;
        hi_d     = hi_q;
        lo_carry = inc_i & ~lo_we_i & (lo_q == 32'hFFFF_FFFF);
        if (lo_we_i) begin
            lo_d = wdata_i;
        end else if (inc_i) begin
            lo_d = lo_q + 32'd1;
        end
        if (hi_we_i) begin
            hi_d = wdata_i;
        end else if (lo_carry) begin
            hi_d = hi_q + 32'd1;
        end
    end

    // Counter state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign value_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_register_file.sv
// Machine-mode CSR storage/update unit for the EX stage: read-modify-write, counters, trap state.
module csr_register_file
    import csr_register_file_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE   = 32'h4000_0100,
    parameter bit          HAS_COUNTERS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic        rd1_rs1_sel,
    input  logic        csr_reg_wr,
    input  logic        csr_reg_rd,
    input  logic [1:0]  csr_wd_select,
    input  logic        ex_stall,
    input  logic        instr_retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_val,
    input  logic        mret_valid,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_global
);

    localparam logic [31:0] MtvecResetVal = MTVEC_RESET & ~32'h3;

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;

    csr_sel_e    sel;
    logic        read_only;
    logic        csr_we;
    logic [31:0] src;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic        retire_en;

    // Address decode, legality and write qualification
    always_comb begin
        sel         = csr_decode(csr_addr);
        read_only   = csr_is_read_only(csr_addr);
        csr_illegal = (csr_reg_rd | csr_reg_wr) &
                      ((sel == SelNone) | (csr_reg_wr & read_only));
        csr_we      = csr_reg_wr & ~ex_stall & ~csr_illegal & ~trap_valid;
        retire_en   = instr_retire & ~ex_stall;
    end

    // Pre-write CSR value; this is both the read data and the RMW operand
    always_comb begin
        old_val = '0;
        case (sel)
            SelMstatus:   old_val = mstatus_pack(mstatus_mie_q, mstatus_mpie_q);
            SelMisa:      old_val = MISA_VALUE;
            SelMie:       old_val = mie_q;
            SelMtvec:     old_val = mtvec_q;
            SelMscratch:  old_val = mscratch_q;
            SelMepc:      old_val = mepc_q;
            SelMcause:    old_val = mcause_q;
            SelMtval:     old_val = mtval_q;
            SelMcycle:    old_val = mcycle[31:0];
            SelMcycleh:   old_val = mcycle[63:32];
            SelMinstret:  old_val = minstret[31:0];
            SelMinstreth: old_val = minstret[63:32];
            default:      old_val = '0;  // mip and unimplemented addresses
        endcase
    end

    // Write-data operand and set/clear/write combination
    always_comb begin
        src       = rd1_rs1_sel ? {27'b0, zimm} : rs1_data;
        new_val   = csr_apply_op(csr_wd_sel_e'(csr_wd_select), old_val, src);
        csr_rdata = csr_reg_rd ? old_val : 32'h0;
    end

    // Next state: trap beats CSR write and mret; mret overrides a same-cycle mstatus write
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        if (trap_valid) begin
            mepc_d         = trap_pc & ~32'h3;
            mcause_d       = trap_cause;
            mtval_d        = trap_val;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else begin
            if (csr_we) begin
                case (sel)
                    SelMstatus: begin
                        mstatus_mie_d  = new_val[MstatusMieBit];
                        mstatus_mpie_d = new_val[MstatusMpieBit];
                    end
                    SelMie:      mie_d      = new_val;
                    SelMtvec:    mtvec_d    = {new_val[31:2], 2'b00};
                    SelMscratch: mscratch_d = new_val;
                    SelMepc:     mepc_d     = {new_val[31:2], 2'b00};
                    SelMcause:   mcause_d   = new_val;
                    SelMtval:    mtval_d    = new_val;
                    default: ;  // counters handled below; misa/mip ignore writes
                endcase
            end
            if (mret_valid) begin
                mstatus_mie_d  = mstatus_mpie_q;
                mstatus_mpie_d = 1'b1;
            end
        end
    end

    // CSR state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MtvecResetVal;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    if (HAS_COUNTERS) begin : g_counters
        csr_counter64 u_mcycle (
            .clk_i   (clk),
            .rst_ni  (rst),
            .inc_i   (1'b1),
            .lo_we_i (csr_we & (sel == SelMcycle)),
            .hi_we_i (csr_we & (sel == SelMcycleh)),
            .wdata_i (new_val),
            .value_o (mcycle)
        );

        csr_counter64 u_minstret (
            .clk_i   (clk),
            .rst_ni  (rst),
            .inc_i   (retire_en),
            .lo_we_i (csr_we & (sel == SelMinstret)),
            .hi_we_i (csr_we & (sel == SelMinstreth)),
            .wdata_i (new_val),
            .value_o (minstret)
        );
    end else begin : g_no_counters
        assign mcycle   = '0;
        assign minstret = '0;
    end

    assign mtvec_o    = mtvec_q;
    assign mepc_o     = mepc_q;
    assign mie_global = mstatus_mie_q;

endmodule

// File: tb/tb_csr_register_file.sv
// Randomized self-checking bench for csr_register_file against a behavioural CSR model.
module tb_csr_register_file;

    localparam logic [31:0] MtvecReset = 32'h8000_0001;
    localparam logic [31:0] MisaValue  = 32'h4000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic [31:0] rs1_data;
    logic [4:0]  zimm;
    logic        rd1_rs1_sel;
    logic        csr_reg_wr;
    logic        csr_reg_rd;
    logic [1:0]  csr_wd_select;
    logic        ex_stall;
    logic        instr_retire;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret_valid;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_global;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic        m_mie, m_mpie;
    logic [31:0] m_mie_csr, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_mcycle, m_minstret;

    // Last sampled outputs for directed checks
    logic [31:0] last_rdata;
    logic        last_ill;
    logic        last_mie;

    logic [11:0] addr_tbl [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                                   12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0,
                                   12'hF11, 12'h000};

    csr_register_file #(
        .MTVEC_RESET  (MtvecReset),
        .MISA_VALUE   (MisaValue),
        .HAS_COUNTERS (1'b1)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .csr_addr      (csr_addr),
        .rs1_data      (rs1_data),
        .zimm          (zimm),
        .rd1_rs1_sel   (rd1_rs1_sel),
        .csr_reg_wr    (csr_reg_wr),
        .csr_reg_rd    (csr_reg_rd),
        .csr_wd_select (csr_wd_select),
        .ex_stall      (ex_stall),
        .instr_retire  (instr_retire),
        .trap_valid    (trap_valid),
        .trap_cause    (trap_cause),
        .trap_pc       (trap_pc),
        .trap_val      (trap_val),
        .mret_valid    (mret_valid),
        .csr_rdata     (csr_rdata),
        .csr_illegal   (csr_illegal),
        .mtvec_o       (mtvec_o),
        .mepc_o        (mepc_o),
        .mie_global    (mie_global)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        m_mie      = 1'b0;
        m_mpie     = 1'b0;
        m_mie_csr  = 32'h0;
        m_mtvec    = MtvecReset & ~32'h3;
        m_mscratch = 32'h0;
        m_mepc     = 32'h0;
        m_mcause   = 32'h0;
        m_mtval    = 32'h0;
        m_mcycle   = 64'h0;
        m_minstret = 64'h0;
    endtask

    function automatic logic [31:0] mdl_value(input logic [11:0] a, output logic legal);
        logic [31:0] v;
        legal = 1'b1;
        v     = 32'h0;
        case (a)
            12'h300: v = 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: v = MisaValue;
            12'h304: v = m_mie_csr;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = 32'h0;
            12'hB00, 12'hC00: v = m_mcycle[31:0];
            12'hB80, 12'hC80: v = m_mcycle[63:32];
            12'hB02, 12'hC02: v = m_minstret[31:0];
            12'hB82, 12'hC82: v = m_minstret[63:32];
            default: legal = 1'b0;
        endcase
        return v;
    endfunction

    // One clock: sample/compare mid-cycle against the model, then advance the model
    task automatic run_cycle();
        logic        legal, ro, exp_ill, we, ret, old_mpie;
        logic [31:0] old, src, nv, lo_inc;
        logic [63:0] cyc_n, ins_n;
        @(negedge clk);
        #2;
        if (!rst) mdl_reset();
        old     = mdl_value(csr_addr, legal);
        ro      = (csr_addr[11:10] == 2'b11) || (csr_addr == 12'h301);
        exp_ill = (csr_reg_rd || csr_reg_wr) && (!legal || (csr_reg_wr && ro));
        last_rdata = csr_rdata;
        last_ill   = csr_illegal;
        last_mie   = mie_global;
        check_eq($sformatf("rdata@%03h", csr_addr), csr_rdata, csr_reg_rd ? old : 32'h0);
        check_eq($sformatf("illegal@%03h", csr_addr), {31'b0, csr_illegal}, {31'b0, exp_ill});
        check_eq("mtvec_o", mtvec_o, m_mtvec);
        check_eq("mepc_o", mepc_o, m_mepc);
        check_eq("mie_global", {31'b0, mie_global}, {31'b0, m_mie});
        if (rst) begin
            src = rd1_rs1_sel ? {27'b0, zimm} : rs1_data;
            case (csr_wd_select)
                2'b01:   nv = old | src;
                2'b10:   nv = old & ~src;
                default: nv = src;
            endcase
            we    = csr_reg_wr && !ex_stall && !exp_ill && !trap_valid;
            ret   = instr_retire && !ex_stall;
            cyc_n = m_mcycle + 64'd1;
            ins_n = m_minstret + (ret ? 64'd1 : 64'd0);
            if (we) begin
                case (csr_addr)
                    12'hB00: cyc_n = {m_mcycle[63:32], nv};
                    12'hB80: begin lo_inc = m_mcycle[31:0] + 32'd1; cyc_n = {nv, lo_inc}; end
                    12'hB02: ins_n = {m_minstret[63:32], nv};
                    12'hB82: begin
                        lo_inc = m_minstret[31:0] + (ret ? 32'd1 : 32'd0);
                        ins_n  = {nv, lo_inc};
                    end
                    default: ;
                endcase
            end
            m_mcycle   = cyc_n;
            m_minstret = ins_n;
            old_mpie   = m_mpie;
            if (trap_valid) begin
                m_mepc   = trap_pc & ~32'h3;
                m_mcause = trap_cause;
                m_mtval  = trap_val;
                m_mpie   = m_mie;
                m_mie    = 1'b0;
            end else begin
                if (we) begin
                    case (csr_addr)
                        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                        12'h304: m_mie_csr  = nv;
                        12'h305: m_mtvec    = nv & ~32'h3;
                        12'h340: m_mscratch = nv;
                        12'h341: m_mepc     = nv & ~32'h3;
                        12'h342: m_mcause   = nv;
                        12'h343: m_mtval    = nv;
                        default: ;
                    endcase
                end
                if (mret_valid) begin
                    m_mie  = old_mpie;
                    m_mpie = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        csr_addr      = 12'h300;
        rs1_data      = 32'h0;
        zimm          = 5'h0;
        rd1_rs1_sel   = 1'b0;
        csr_reg_wr    = 1'b0;
        csr_reg_rd    = 1'b0;
        csr_wd_select = 2'b00;
        ex_stall      = 1'b0;
        instr_retire  = 1'b0;
        trap_valid    = 1'b0;
        trap_cause    = 32'h0;
        trap_pc       = 32'h0;
        trap_val      = 32'h0;
        mret_valid    = 1'b0;
    endtask

    task automatic csr_op(input logic [11:0] a, input logic wr, input logic [1:0] op,
                          input logic use_zimm, input logic [31:0] val);
        set_idle();
        csr_addr      = a;
        csr_reg_rd    = 1'b1;
        csr_reg_wr    = wr;
        csr_wd_select = op;
        rd1_rs1_sel   = use_zimm;
        rs1_data      = val;
        zimm          = val[4:0];
    endtask

    initial begin
        rst = 1'b0;
        set_idle();
        mdl_reset();
        run_cycle();
        run_cycle();
        rst = 1'b1;

        // Reset values
        csr_op(12'h300, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();
        check_eq("rst_mstatus", last_rdata, 32'h0000_1800);
        check_eq("rst_illegal", {31'b0, last_ill}, 32'h0);
        csr_op(12'h305, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();
        check_eq("rst_mtvec", last_rdata, 32'h8000_0000);
        csr_op(12'h301, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();
        check_eq("rst_misa", last_rdata, 32'h4000_0100);

        // mscratch write / set / clear
        csr_op(12'h340, 1'b1, 2'b00, 1'b0, 32'hDEAD_BEEF); run_cycle();
        csr_op(12'h340, 1'b1, 2'b01, 1'b1, 32'h0000_0010); run_cycle();
        csr_op(12'h340, 1'b1, 2'b10, 1'b0, 32'h0000_000F); run_cycle();
        check_eq("mscratch_set", last_rdata, 32'hDEAD_BEFF);
        csr_op(12'h340, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();
        check_eq("mscratch_clr", last_rdata, 32'hDEAD_BEF0);

        // Illegal writes, mtvec alignment
        csr_op(12'hC00, 1'b1, 2'b00, 1'b0, 32'h1234_5678); csr_reg_rd = 1'b0; run_cycle();
        check_eq("wr_c00_ill", {31'b0, last_ill}, 32'h1);
        csr_op(12'h7C0, 1'b1, 2'b00, 1'b0, 32'h1234_5678); csr_reg_rd = 1'b0; run_cycle();
        check_eq("wr_7c0_ill", {31'b0, last_ill}, 32'h1);
        csr_op(12'h305, 1'b1, 2'b00, 1'b0, 32'h0000_0103); run_cycle();
        csr_op(12'h305, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();
        check_eq("mtvec_align", last_rdata, 32'h0000_0100);

        // mcycle carry from a written lo half
        csr_op(12'hB80, 1'b1, 2'b00, 1'b0, 32'h0); run_cycle();
        csr_op(12'hB00, 1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF); run_cycle();
        csr_op(12'hB00, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();
        check_eq("mcycle_lo_max", last_rdata, 32'hFFFF_FFFF);
        csr_op(12'hB80, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();
        check_eq("mcycle_hi_carry", last_rdata, 32'h1);

        // minstret hi write with a retiring instruction
        csr_op(12'hB82, 1'b1, 2'b00, 1'b0, 32'h0000_0055); instr_retire = 1'b1; run_cycle();
        csr_op(12'hB82, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();
        check_eq("minstret_hi", last_rdata, 32'h0000_0055);
        csr_op(12'hB02, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();

        // Trap with concurrent write, then mret
        csr_op(12'h300, 1'b1, 2'b00, 1'b0, 32'h0000_0008); run_cycle();
        csr_op(12'h340, 1'b1, 2'b00, 1'b0, 32'h0BAD_0BAD);
        trap_valid = 1'b1; trap_pc = 32'h80; trap_cause = 32'h2; trap_val = 32'h1234;
        run_cycle();
        csr_op(12'h341, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();
        check_eq("trap_mepc", last_rdata, 32'h80);
        check_eq("trap_mie", {31'b0, last_mie}, 32'h0);
        csr_op(12'h342, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();
        check_eq("trap_mcause", last_rdata, 32'h2);
        csr_op(12'h300, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();
        check_eq("trap_mstatus", last_rdata, 32'h0000_1880);
        csr_op(12'h340, 1'b0, 2'b00, 1'b0, 32'h0); run_cycle();
        check_eq("trap_wr_dropped", last_rdata, 32'hDEAD_BEF0);
        set_idle(); mret_valid = 1'b1; run_cycle();
        set_idle(); run_cycle();
        check_eq("mret_mie", {31'b0, last_mie}, 32'h1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            set_idle();
            csr_addr      = addr_tbl[$urandom_range(0, 19)];
            rs1_data      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            zimm          = 5'($urandom);
            rd1_rs1_sel   = 1'($urandom);
            csr_reg_wr    = 1'($urandom);
            csr_reg_rd    = ($urandom_range(0, 3) != 0);
            csr_wd_select = 2'($urandom);
            ex_stall      = ($urandom_range(0, 3) == 0);
            instr_retire  = 1'($urandom);
            trap_valid    = ($urandom_range(0, 15) == 0);
            trap_cause    = $urandom;
            trap_pc       = $urandom;
            trap_val      = $urandom;
            mret_valid    = ($urandom_range(0, 7) == 0);
            run_cycle();
        end

        // Reset mid-stream with counters running
        csr_op(12'hB00, 1'b0, 2'b00, 1'b0, 32'h0);
        instr_retire = 1'b1;
        rst = 1'b0;
        #1;
        check_eq("midrst_mepc", mepc_o, 32'h0);
        check_eq("midrst_mtvec", mtvec_o, 32'h8000_0000);
        check_eq("midrst_mie", {31'b0, mie_global}, 32'h0);
        check_eq("midrst_mcycle", csr_rdata, 32'h0);
        run_cycle();
        run_cycle();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            csr_op((i % 2 == 0) ? 12'hB00 : 12'hB02, 1'b0, 2'b00, 1'b0, 32'h0);
            instr_retire = 1'b1;
            run_cycle();
        end
        check_eq("resume_minstret", last_rdata, 32'h3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
